// File: rtl/logic_mux2_reg.sv
// Two-input selector: y follows a when c is low, b when c is high.
// With OUT_REG=1 the selected value is retimed to clk and cleared by rst_n.
module logic_mux2_reg #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] y
);

  // The conditional operator merges operands bitwise when c is unknown,
  // so bits where a and b agree stay known instead of turning to X.
  logic [WIDTH-1:0] sel;
  assign sel = c ? b : a;

  generate
    if (OUT_REG) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y <= '0;
        end else begin
          y <= sel;
        end
      end
    end else begin : g_comb
      // clk and rst_n are intentionally unused in the combinational variant.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign y = sel;
    end
  endgenerate

endmodule

// File: tb/tb_logic_mux2_reg.sv
// Directed self-checking bench for logic_mux2_reg covering combinational and
// registered variants at WIDTH=1 and WIDTH=8.
module tb_logic_mux2_reg;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, c1;
  logic       y_comb1, y_reg1;
  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] y_comb8, y_reg8;

  int vectors;
  int miscompares;

  logic [7:0] truth;
  logic       probe_x;

  logic_mux2_reg #(.WIDTH(1), .OUT_REG(1'b0)) u_comb1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .y(y_comb1));

  logic_mux2_reg #(.WIDTH(1), .OUT_REG(1'b1)) u_reg1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .y(y_reg1));

  logic_mux2_reg #(.WIDTH(8), .OUT_REG(1'b0)) u_comb8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .y(y_comb8));

  logic_mux2_reg #(.WIDTH(8), .OUT_REG(1'b1)) u_reg8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .y(y_reg8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    // Bit {a,b,c} holds the expected y for that input combination.
    truth   = 8'b1101_1000;
    probe_x = 1'bx;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

    #2;
    check_output("reset_reg1", {7'd0, y_reg1}, 8'h00);
    check_output("reset_reg8", y_reg8, 8'h00);
    check_output("reset_comb1", {7'd0, y_comb1}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed steps 1 and 2: c=0 ignores b, then c toggles 0->1->0.
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    #1 check_output("c0_ignores_b", {7'd0, y_comb1}, 8'h00);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    #1 check_output("c1_all_ones", {7'd0, y_comb1}, 8'h01);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    #1 check_output("c_back_to_0", {7'd0, y_comb1}, 8'h00);

    // Exhaustive truth table, combinational and one cycle later registered.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a1, b1, c1} = i[2:0];
      #1 check_output($sformatf("tt_comb_%0d", i), {7'd0, y_comb1}, {7'd0, truth[i]});
      @(posedge clk);
      #1 check_output($sformatf("tt_reg_%0d", i), {7'd0, y_reg1}, {7'd0, truth[i]});
    end

    // Registered latency and asynchronous reset between edges.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk);
    #1 check_output("reg_pre_zero", {7'd0, y_reg1}, 8'h00);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    #1 check_output("reg_holds_before_edge", {7'd0, y_reg1}, 8'h00);
    @(posedge clk);
    #1 check_output("reg_after_edge", {7'd0, y_reg1}, 8'h01);
    #2 rst_n = 1'b0;
    #1 check_output("async_reset_reg1", {7'd0, y_reg1}, 8'h00);
    check_output("reset_no_effect_comb1", {7'd0, y_comb1}, 8'h01);
    @(posedge clk);
    #1 check_output("reset_holds_reg1", {7'd0, y_reg1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_output("released_before_edge", {7'd0, y_reg1}, 8'h00);
    @(posedge clk);
    #1 check_output("released_first_edge", {7'd0, y_reg1}, 8'h01);

    // WIDTH=8 steering and simultaneous a/c change.
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; c8 = 1'b0;
    #1 check_output("w8_c0", y_comb8, 8'hA5);
    @(negedge clk);
    c8 = 1'b1;
    #1 check_output("w8_c1", y_comb8, 8'h3C);
    @(posedge clk);
    #1 check_output("w8_reg_c1", y_reg8, 8'h3C);
    @(negedge clk);
    a8 = 8'hFF; c8 = 1'b0;
    #1 check_output("w8_same_step", y_comb8, 8'hFF);
    check_output("w8_reg_not_yet", y_reg8, 8'h3C);
    @(posedge clk);
    #1 check_output("w8_reg_same_step", y_reg8, 8'hFF);
    #2 rst_n = 1'b0;
    #1 check_output("w8_async_reset", y_reg8, 8'h00);
    check_output("w8_comb_during_reset", y_comb8, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Unknown select: agreeing data bits must not become X.
    a1 = 1'b1; b1 = 1'b1; c1 = 1'bx;
    #1 check_output("cx_equal_ones", {7'd0, y_comb1}, 8'h01);
    @(posedge clk);
    #1 check_output("cx_equal_reg", {7'd0, y_reg1}, 8'h01);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0;
    #1 check_output("cx_equal_zeros", {7'd0, y_comb1}, 8'h00);
    a8 = 8'hF0; b8 = 8'hFF; c8 = 1'bx;
    #1 check_output("cx_w8_upper", {4'd0, y_comb8[7:4]}, 8'h0F);
    if ($isunknown(probe_x)) begin
      a1 = 1'b1; b1 = 1'b0;
      #1 check_output("cx_differ", {7'd0, y_comb1}, {7'd0, 1'bx});
      check_output("cx_w8_lower", {4'd0, y_comb8[3:0]}, {4'd0, 4'bxxxx});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
